forward_select_unit: RTL and testbench
======================================

FORWARD_SELECT_UNIT -- requirements
Module: forward_select_unit

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, register-address width.
REQ-002 SHALL have port clk, input, 1, the only clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port id_valid, input, 1: an instruction in decode requests issue to EX.
REQ-005 SHALL have ports id_rs1 and id_rs2, input, REG_ADDR_W each: decode source registers.
REQ-006 SHALL have ports id_use_rs1 and id_use_rs2, input, 1 each: the matching source is actually read.
REQ-007 SHALL have port id_rd, input, REG_ADDR_W: decode destination register.
REQ-008 SHALL have port id_reg_write, input, 1: decode instruction writes id_rd.
REQ-009 SHALL have port id_is_load, input, 1: decode instruction is a load.
REQ-010 SHALL have port flush, input, 1: squash the decode instruction; no issue this cycle.
REQ-011 SHALL have ports fwd_sel_a and fwd_sel_b, output, 2 each, registered: select codes for the EX operand 4:1 muxes.
REQ-012 SHALL have port stall, output, 1, combinational: hold fetch/decode and insert an EX bubble.

Function
REQ-013 SHALL track in-flight writers in four stage slots EX, MEM, WB, RET; each slot holds valid, rd, reg_write and is_load.
REQ-014 SHALL advance every cycle: RET<=WB, WB<=MEM, MEM<=EX, EX<=issued entry; slots do not freeze on stall.
REQ-015 SHALL issue the decode entry into EX iff id_valid & ~stall & ~flush; otherwise EX receives a bubble (valid=0).
REQ-016 SHALL treat a slot as a forwarding source only when valid & reg_write & rd!=0 & rd==rs & use_rs.
REQ-017 SHALL encode selects: 00 register file; 01 EX/MEM result (EX slot match); 10 MEM/WB result (MEM slot match); 11 retire result (WB slot match).
REQ-018 SHALL give priority to the youngest match: EX slot over MEM slot over WB slot.
REQ-019 SHALL evaluate selects against the pre-edge slots and register them on the edge that issues the instruction, so they are valid for the full EX cycle.
REQ-020 SHALL load 00 into both selects whenever a bubble enters EX.
REQ-021 SHALL assert stall when id_valid & ~flush and the EX slot holds a valid load with rd!=0 matching a used source (load-use hazard).
REQ-022 SHALL keep the load-use stall to exactly one cycle; on the next cycle the load is in MEM and forwarding uses code 10.
REQ-023 SHALL force stall to 0 when flush is high, because flush has priority over stall.
REQ-024 SHALL never produce a nonzero select for rs=0, in any slot state.
REQ-025 SHALL handle rs1==rs2 with both selects resolved independently and identically.

Reset
REQ-026 SHALL, while rst_n=0, clear all slot valid bits and set fwd_sel_a=fwd_sel_b=00 immediately, without waiting for clk; stall then reads 0.
REQ-027 SHALL, when reset is asserted mid-stall or mid-flight, discard all in-flight entries; the first post-reset issue sees register-file selects only.

Configuration
REQ-028 SHALL, with macro FWD_RETIRE_BYPASS_EN defined, generate code 11 for WB-slot matches per REQ-017.
REQ-029 SHALL, without FWD_RETIRE_BYPASS_EN, omit the WB-to-RET match logic and return 00 for WB-slot matches, because the register file is then write-through; code 11 is never produced.

Verification
REQ-030 SHALL cover EX hit: issue add x5 (rd=5, reg_write), then the next cycle add x6,x5,x7 -> fwd_sel_a=01 and fwd_sel_b=00 in its EX cycle.
REQ-031 SHALL cover the priority case: writers of x5 at distance 1 and 2, then a reader of x5 -> fwd_sel_a=01, not 10.
REQ-032 SHALL cover load-use: lw x8, then immediately add x9,x8,x8 -> stall=1 for one cycle, EX bubble with selects 00, then fwd_sel_a=fwd_sel_b=10.
REQ-033 SHALL cover x0 and distance 3: writer of x0 then a reader of x0 -> 00; writer of x3 three issues ahead -> 11 with FWD_RETIRE_BYPASS_EN, 00 without.
REQ-034 SHALL cover flush during a load-use hazard: flush=1 -> stall=0 and a bubble enters EX; after flush drops, no stale stall occurs.
REQ-035 SHALL cover asynchronous reset mid-stall: drop rst_n between edges -> selects 00 and stall 0 immediately; the first reader after release gets 00.

Source files
------------

// File: rtl/forward_select_unit.sv
// forward_select_unit
//   Operand forwarding and load-use hazard control for a 5-stage style
//   integer pipeline. Four stage slots (EX, MEM, WB, RET) track in-flight
//   writers. For each decode source operand, a select code is computed
//   against the slots as they stand before the edge. That code is registered
//   on the issue edge, so it stays stable for the whole EX cycle.
//
//   Select codes: 00 regfile, 01 EX/MEM result, 10 MEM/WB result,
//                 11 retire result (only with FWD_RETIRE_BYPASS_EN).
//
//   Build option: define FWD_RETIRE_BYPASS_EN to enable WB-slot forwarding
//   (code 11). Without it the register file is write-through, so WB-slot
//   matches read the register file (code 00).
//
// Ports
//   clk, rst_n                   clock, async active-low reset
//   id_valid                     decode instruction requests issue
//   id_rs1/id_rs2, id_use_rs1/2  decode sources and source-read enables
//   id_rd, id_reg_write          decode destination and write enable
//   id_is_load                   decode instruction is a load
//   flush                        squash decode instruction this cycle
//   fwd_sel_a, fwd_sel_b         registered EX operand mux selects
//   stall                        combinational load-use stall

// Per-operand select: the highest-priority (youngest) matching source wins.
module fwd_operand_sel #(
  parameter int REG_ADDR_W = 5,
  parameter int NSRC       = 3
) (
  input  logic [REG_ADDR_W-1:0]           rs,
  input  logic                            use_rs,
  input  logic [NSRC-1:0]                 wr_ok,
  input  logic [NSRC-1:0][REG_ADDR_W-1:0] src_rd,
  output logic [1:0]                      sel
);
  always_comb begin
    sel = 2'b00;
    if (use_rs && rs != '0) begin
      // Walk oldest to youngest so a younger hit overwrites an older one.
      for (int j = NSRC-1; j >= 0; j--)
        if (wr_ok[j] && src_rd[j] == rs) sel = 2'(j + 1);
    end
  end
endmodule

module forward_select_unit #(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_is_load,
  input  logic                  flush,
  output logic [1:0]            fwd_sel_a,
  output logic [1:0]            fwd_sel_b,
  output logic                  stall
);
  localparam int STAGES  = 4;  // 0 EX, 1 MEM, 2 WB, 3 RET
  localparam int NUM_OPS = 2;
`ifdef FWD_RETIRE_BYPASS_EN
  localparam int NSRC = 3;     // EX, MEM, WB
`else
  localparam int NSRC = 2;     // EX, MEM; WB handled by write-through regfile
`endif

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  is_load;
  } slot_t;

  logic  [STAGES-1:0]      vld_pipe;
  slot_t [STAGES-1:0]      slot_pipe;
  slot_t                   id_entry;
  logic                    issue;
  logic                    load_hit;

  logic [NSRC-1:0]                     wr_ok;
  logic [NSRC-1:0][REG_ADDR_W-1:0]     src_rd;
  logic [NUM_OPS-1:0][REG_ADDR_W-1:0]  op_rs;
  logic [NUM_OPS-1:0]                  op_use;
  logic [NUM_OPS-1:0][1:0]             sel_nxt;

  assign id_entry = '{rd: id_rd, reg_write: id_reg_write, is_load: id_is_load};
  assign op_rs    = {id_rs2, id_rs1};
  assign op_use   = {id_use_rs2, id_use_rs1};

  for (genvar j = 0; j < NSRC; j++) begin : g_src
    assign wr_ok[j]  = vld_pipe[j] & slot_pipe[j].reg_write & (slot_pipe[j].rd != '0);
    assign src_rd[j] = slot_pipe[j].rd;
  end

  for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
    fwd_operand_sel #(.REG_ADDR_W(REG_ADDR_W), .NSRC(NSRC)) u_op (
      .rs     (op_rs[i]),
      .use_rs (op_use[i]),
      .wr_ok  (wr_ok),
      .src_rd (src_rd),
      .sel    (sel_nxt[i])
    );
  end

  // A load in EX has no data until MEM; any reader needs one bubble.
  assign load_hit = vld_pipe[0] & slot_pipe[0].is_load & (slot_pipe[0].rd != '0) &
                    ((id_use_rs1 & (slot_pipe[0].rd == id_rs1)) |
                     (id_use_rs2 & (slot_pipe[0].rd == id_rs2)));
  assign stall = id_valid & ~flush & load_hit;
  assign issue = id_valid & ~stall & ~flush;

  // Slots shift unconditionally; a stall only turns the EX entry into a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      slot_pipe <= '0;
      fwd_sel_a <= 2'b00;
      fwd_sel_b <= 2'b00;
    end else begin
      vld_pipe  <= {vld_pipe[STAGES-2:0], issue};
      slot_pipe <= {slot_pipe[STAGES-2:0], id_entry};
      fwd_sel_a <= issue ? sel_nxt[0] : 2'b00;
      fwd_sel_b <= issue ? sel_nxt[1] : 2'b00;
    end
  end

  // RET slot and later-stage is_load bits are tracked but not consulted.
  logic unused_slot_bits;
  assign unused_slot_bits = ^{vld_pipe, slot_pipe};
endmodule

// File: tb/tb_forward_select_unit.sv
module tb_forward_select_unit;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_use_rs1, id_use_rs2, id_reg_write, id_is_load, flush;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic [1:0] fwd_sel_a, fwd_sel_b;
  logic       stall;

  int checks = 0;
  int errors = 0;

  forward_select_unit #(.REG_ADDR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_is_load(id_is_load), .flush(flush),
    .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b), .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       vld;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] rd;
    logic       rw, ld, fl;
    logic       st;       // expected stall before the edge
    logic [1:0] ea, eb;   // expected selects after the edge
  } vec_t;

  vec_t vecs[$];

  // WB-slot forwarding code depends on the build option.
  function automatic logic [1:0] wbx(input logic [1:0] c);
`ifdef FWD_RETIRE_BYPASS_EN
    return c;
`else
    return (c == 2'b11) ? 2'b00 : c;
`endif
  endfunction

  function automatic void av(input logic vld, input int rs1, input int rs2,
                             input logic u1, input logic u2, input int rd,
                             input logic rw, input logic ld, input logic fl,
                             input logic st, input logic [1:0] ea, input logic [1:0] eb);
    vec_t v;
    v.vld = vld; v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.u1 = u1; v.u2 = u2;
    v.rd = 5'(rd); v.rw = rw; v.ld = ld; v.fl = fl; v.st = st; v.ea = ea; v.eb = eb;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    id_valid = v.vld; id_rs1 = v.rs1; id_rs2 = v.rs2; id_use_rs1 = v.u1; id_use_rs2 = v.u2;
    id_rd = v.rd; id_reg_write = v.rw; id_is_load = v.ld; flush = v.fl;
  endtask

  // Called 1 time unit after a rising edge.
  task automatic run_vec(input vec_t v, input string tag);
    drive(v);
    #1 chk({tag, ".stall"}, {1'b0, stall}, {1'b0, v.st});
    @(posedge clk);
    #1;
    chk({tag, ".sel_a"}, fwd_sel_a, v.ea);
    chk({tag, ".sel_b"}, fwd_sel_b, v.eb);
  endtask

  initial begin
    vec_t h;
    //  vld rs1 rs2 u1 u2 rd rw ld fl  st  ea          eb
    av(1, 1, 2, 1, 1, 5, 1, 0, 0, 0, 2'b00, 2'b00);      // 0  add x5
    av(1, 5, 7, 1, 1, 6, 1, 0, 0, 0, 2'b01, 2'b00);      // 1  add x6,x5,x7 : EX hit
    av(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 2'b00, 2'b00);      // 2  writer x5
    av(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 2'b00, 2'b00);      // 3  writer x5
    av(1, 5, 5, 1, 1, 10, 1, 0, 0, 0, 2'b01, 2'b01);     // 4  priority EX over MEM, rs1==rs2
    av(1, 5, 5, 1, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00);      // 5  MEM hit, rs2 unused
    av(1, 5, 10, 1, 1, 0, 0, 0, 0, 0, wbx(2'b11), 2'b10);// 6  WB hit / MEM hit
    av(1, 1, 0, 1, 0, 8, 1, 1, 0, 0, 2'b00, 2'b00);      // 7  lw x8
    av(1, 8, 8, 1, 1, 9, 1, 0, 0, 1, 2'b00, 2'b00);      // 8  load-use: stall, bubble
    av(1, 8, 8, 1, 1, 9, 1, 0, 0, 0, 2'b10, 2'b10);      // 9  reissue: MEM forward
    av(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00);      // 10 writer x0
    av(1, 0, 0, 1, 1, 3, 1, 0, 0, 0, 2'b00, 2'b00);      // 11 reader x0 -> 00
    av(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);      // 12 nop
    av(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);      // 13 nop
    av(1, 3, 9, 1, 1, 0, 0, 0, 0, 0, wbx(2'b11), 2'b00); // 14 x3 at distance 3; x9 retired
    av(1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 2'b00, 2'b00);      // 15 lw x4
    av(1, 4, 0, 1, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00);      // 16 flush over load-use
    av(1, 4, 0, 1, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00);      // 17 no stale stall, MEM hit
    av(0, 4, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);      // 18 no request -> bubble
    av(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 2'b00, 2'b00);      // 19 lw x7
    av(0, 7, 0, 1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);      // 20 idle reader: no stall
    av(1, 7, 7, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);      // 21 sources unused

    h = vecs[0]; h.vld = 0;
    drive(h);
    rst_n = 1'b0;
    #2;
    chk("reset.sel_a", fwd_sel_a, 2'b00);
    chk("reset.sel_b", fwd_sel_b, 2'b00);
    chk("reset.stall", {1'b0, stall}, 2'b00);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++)
      run_vec(vecs[i], $sformatf("v%0d", i));

    // Async reset in the middle of a load-use stall.
    h = vecs[2];                                    // writer x5
    run_vec(h, "r0");
    h = vecs[7]; h.rs1 = 5; h.ea = 2'b01;           // lw x8 reading x5 -> EX hit
    run_vec(h, "r1");
    h = vecs[8];                                    // reader x8
    drive(h);
    #1 chk("r2.stall_pre", {1'b0, stall}, 2'b01);
    chk("r2.sel_a_pre", fwd_sel_a, 2'b01);
    #2 rst_n = 1'b0;                                // between edges
    #1;
    chk("r2.stall_rst", {1'b0, stall}, 2'b00);
    chk("r2.sel_a_rst", fwd_sel_a, 2'b00);
    chk("r2.sel_b_rst", fwd_sel_b, 2'b00);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    h = vecs[8]; h.rs2 = 5; h.st = 0;               // reader x8/x5 sees regfile only
    run_vec(h, "r3");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule
